pstwo_poll_engine: RTL and testbench



---
 rtl/pstwo_pkg.sv | 47 ++++
 rtl/pstwo_poll_engine_byte_xfer.sv | 113 +++++++++++
 rtl/pstwo_poll_engine.sv | 237 +++++++++++++++++++++++
 tb/tb_pstwo_poll_engine.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pstwo_pkg.sv
// ----------------------------------------------------------------------------
// pstwo_pkg
// Shared constants and types for the PlayStation-2 gamepad poll engine.
//   - Poll frame command bytes and the helper that selects them by index
//   - Response signature and pad identification codes
//   - Frame-level and bit-level state enumerations
// ----------------------------------------------------------------------------
package pstwo_pkg;

    localparam logic [7:0] CMD_POLL_0   = 8'h01;
    localparam logic [7:0] CMD_POLL_1   = 8'h42;
    localparam logic [7:0] CMD_FILL     = 8'h00;
    localparam logic [7:0] RESP_SIG     = 8'h5A;
    localparam logic [7:0] ID_DIGITAL   = 8'h41;
    localparam logic [7:0] ID_ANALOG    = 8'h73;
    localparam logic [7:0] STICK_CENTER = 8'h80;
    localparam int unsigned FRAME_BYTES = 9;

    // Frame sequencing states owned by the top level.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_XFER  = 3'd2,
        ST_GAP   = 3'd3,
        ST_HOLD  = 3'd4,
        ST_DONE  = 3'd5
    } frame_state_e;

    // Bit-level phases owned by the byte exchanger (LOW/HIGH clock halves).
    typedef enum logic [1:0] {
        PH_IDLE = 2'd0,
        PH_LOW  = 2'd1,
        PH_HIGH = 2'd2
    } bit_phase_e;

    // Command byte sent at a given position of the poll frame.
    function automatic logic [7:0] cmd_byte(input logic [3:0] idx);
        logic [7:0] b;
        case (idx)
            4'd0:    b = CMD_POLL_0;
            4'd1:    b = CMD_POLL_1;
            default: b = CMD_FILL;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/pstwo_poll_engine_byte_xfer.sv
// ----------------------------------------------------------------------------
// pstwo_byte_xfer
// One LSB-first byte exchange on the PS2 link: drives CLK low/high for
// CLK_HALF cycles each, presents command bits on DO while CLK is low and
// samples the synchronized DI on the last cycle of each high half.
// Ports:
//   clk_i, rst_ni   clock, synchronous active-low reset
//   start_i         begin an exchange (only honoured when idle)
//   tx_byte_i       command byte, captured on start
//   di_i            synchronized response data from the pad
//   rx_byte_o       assembled response byte, valid while done_o is high
//   done_o          high during the final cycle of the exchange
//   sclk_o, sdo_o   registered pin drive for PS2_CLK / PS2_DO (idle high)
// ----------------------------------------------------------------------------
module pstwo_byte_xfer
    import pstwo_pkg::*;
#(
    parameter int unsigned CLK_HALF = 100,
    parameter int unsigned CNT_W    = 20
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic [7:0] tx_byte_i,
    input  logic       di_i,
    output logic [7:0] rx_byte_o,
    output logic       done_o,
    output logic       sclk_o,
    output logic       sdo_o
);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_HALF - 1);

    bit_phase_e       phase_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;
    logic [6:0]       shift_q;
    logic [7:0]       tx_q;
    logic             sclk_q;
    logic             sdo_q;
    logic             half_last_s;

    // Terminal-count decode and completion flag. done_o and rx_byte_o are
    // combinational so the frame sequencer can move on in the same cycle
    // the last bit is sampled, keeping a byte exactly 16*CLK_HALF long.
    always_comb begin
        half_last_s = (cnt_q == HALF_LAST);
        done_o      = (phase_q == PH_HIGH) && half_last_s && (bit_idx_q == 3'd7);
        rx_byte_o   = {di_i, shift_q};
    end

    // Bit phase sequencer with registered pin drive.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            phase_q   <= PH_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 7'h7F;
            tx_q      <= 8'hFF;
            sclk_q    <= 1'b1;
            sdo_q     <= 1'b1;
        end else begin
            case (phase_q)
                PH_IDLE: begin
                    if (start_i) begin
                        phase_q   <= PH_LOW;
                        cnt_q     <= '0;
                        bit_idx_q <= 3'd0;
                        tx_q      <= tx_byte_i;
                        sclk_q    <= 1'b0;
                        sdo_q     <= tx_byte_i[0];
                    end
                end
                PH_LOW: begin
                    if (half_last_s) begin
                        phase_q <= PH_HIGH;
                        cnt_q   <= '0;
                        sclk_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                PH_HIGH: begin
                    if (half_last_s) begin
                        cnt_q <= '0;
                        if (bit_idx_q != 3'd7) begin
                            shift_q[bit_idx_q] <= di_i;
                            bit_idx_q          <= bit_idx_q + 3'd1;
                            phase_q            <= PH_LOW;
                            sclk_q             <= 1'b0;
                            sdo_q              <= tx_q[bit_idx_q + 3'd1];
                        end else begin
                            // Bit 7 is taken straight from di_i via rx_byte_o.
                            phase_q <= PH_IDLE;
                            sdo_q   <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    phase_q <= PH_IDLE;
                    sclk_q  <= 1'b1;
                    sdo_q   <= 1'b1;
                end
            endcase
        end
    end

    assign sclk_o = sclk_q;
    assign sdo_o  = sdo_q;

endmodule

// File: rtl/pstwo_poll_engine.sv
// ----------------------------------------------------------------------------
// pstwo_poll_engine
// Autonomous PS2 gamepad poller: runs the 9-byte poll frame (01 42 00x7),
// collects the response and publishes buttons/sticks/pad id when the frame
// carries the 0x5A signature.
// Ports:
//   PCLK, PRESETn      clock, synchronous active-low reset
//   enable             auto-poll every POLL_PERIOD cycles while high
//   poll_req           one-cycle request for an immediate frame (if idle)
//   busy               high from frame start through DONE
//   PS2_CS/CLK/DO      pad pin drive (all idle high)
//   PS2_DI             asynchronous pad response data
//   keys               {byte4, byte3}, active low
//   stick_rx..ly       response bytes 5..8
//   pad_id             response byte 1
//   frame_valid/err    one-cycle pulses for accepted/rejected frames
// ----------------------------------------------------------------------------
module pstwo_poll_engine
    import pstwo_pkg::*;
#(
    parameter int unsigned CLK_HALF    = 100,
    parameter int unsigned BYTE_GAP    = 800,
    parameter int unsigned CS_SETUP    = 800,
    parameter int unsigned POLL_PERIOD = 1000000,
    parameter int unsigned CNT_W       = 20
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        enable,
    input  logic        poll_req,
    output logic        busy,
    output logic        PS2_CS,
    output logic        PS2_CLK,
    output logic        PS2_DO,
    input  logic        PS2_DI,
    output logic [15:0] keys,
    output logic [7:0]  stick_rx,
    output logic [7:0]  stick_ry,
    output logic [7:0]  stick_lx,
    output logic [7:0]  stick_ly,
    output logic [7:0]  pad_id,
    output logic        frame_valid,
    output logic        frame_err
);

    // SETUP holds an entry cycle (CS drops) followed by CS_SETUP wait cycles.
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(BYTE_GAP - 1);
    localparam logic [CNT_W-1:0] POLL_LAST  = CNT_W'(POLL_PERIOD - 1);

    frame_state_e     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] poll_q;
    logic [3:0]       byte_idx_q;
    logic [7:0]       resp_q [FRAME_BYTES];
    logic             cs_q;
    logic             busy_q;
    logic             di_meta_q;
    logic             di_sync_q;
    logic [15:0]      keys_q;
    logic [7:0]       rx_q, ry_q, lx_q, ly_q, pad_id_q;
    logic             valid_q;
    logic             err_q;

    logic             poll_fire_s;
    logic             xfer_start_s;
    logic [3:0]       tx_idx_s;
    logic [7:0]       tx_byte_s;
    logic [7:0]       rx_byte_s;
    logic             xfer_done_s;

    // Two-flop synchronizer for the asynchronous pad data line.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            di_meta_q <= 1'b1;
            di_sync_q <= 1'b1;
        end else begin
            di_meta_q <= PS2_DI;
            di_sync_q <= di_meta_q;
        end
    end

    // Frame trigger and byte-exchange launch decode.
    always_comb begin
        poll_fire_s  = 1'b0;
        xfer_start_s = 1'b0;
        tx_idx_s     = byte_idx_q;
        if (state_q == ST_IDLE) begin
            poll_fire_s = poll_req || (enable && (poll_q == POLL_LAST));
        end else begin
            poll_fire_s = 1'b0;
        end
        if ((state_q == ST_SETUP) && (cnt_q == SETUP_LAST)) begin
            xfer_start_s = 1'b1;
        end else if ((state_q == ST_GAP) && (cnt_q == GAP_LAST)) begin
            // The exchange launched from GAP carries the next byte.
            xfer_start_s = 1'b1;
            tx_idx_s     = byte_idx_q + 4'd1;
        end else begin
            xfer_start_s = 1'b0;
        end
        tx_byte_s = cmd_byte(tx_idx_s);
    end

    pstwo_byte_xfer #(
        .CLK_HALF (CLK_HALF),
        .CNT_W    (CNT_W)
    ) u_xfer (
        .clk_i     (PCLK),
        .rst_ni    (PRESETn),
        .start_i   (xfer_start_s),
        .tx_byte_i (tx_byte_s),
        .di_i      (di_sync_q),
        .rx_byte_o (rx_byte_s),
        .done_o    (xfer_done_s),
        .sclk_o    (PS2_CLK),
        .sdo_o     (PS2_DO)
    );

    // Frame sequencer: CS framing, inter-byte gaps, validation and outputs.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            poll_q     <= '0;
            byte_idx_q <= 4'd0;
            for (int i = 0; i < FRAME_BYTES; i++) begin
                resp_q[i] <= 8'h00;
            end
            cs_q       <= 1'b1;
            busy_q     <= 1'b0;
            keys_q     <= 16'hFFFF;
            rx_q       <= STICK_CENTER;
            ry_q       <= STICK_CENTER;
            lx_q       <= STICK_CENTER;
            ly_q       <= STICK_CENTER;
            pad_id_q   <= 8'h00;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (poll_fire_s) begin
                        state_q    <= ST_SETUP;
                        cnt_q      <= '0;
                        poll_q     <= '0;
                        byte_idx_q <= 4'd0;
                        cs_q       <= 1'b0;
                        busy_q     <= 1'b1;
                    end else if (enable) begin
                        poll_q <= poll_q + 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (cnt_q == SETUP_LAST) begin
                        state_q <= ST_XFER;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_XFER: begin
                    if (xfer_done_s) begin
                        resp_q[byte_idx_q] <= rx_byte_s;
                        cnt_q              <= '0;
                        if (byte_idx_q == 4'd8) begin
                            state_q <= ST_HOLD;
                        end else begin
                            state_q <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        byte_idx_q <= byte_idx_q + 4'd1;
                        state_q    <= ST_XFER;
                        cnt_q      <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        cs_q    <= 1'b1;
                        state_q <= ST_DONE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (resp_q[2] == RESP_SIG) begin
                        keys_q   <= {resp_q[4], resp_q[3]};
                        pad_id_q <= resp_q[1];
                        // A digital pad has no analog bytes; report centred sticks.
                        if (resp_q[1] == ID_DIGITAL) begin
                            rx_q <= STICK_CENTER;
                            ry_q <= STICK_CENTER;
                            lx_q <= STICK_CENTER;
                            ly_q <= STICK_CENTER;
                        end else begin
                            rx_q <= resp_q[5];
                            ry_q <= resp_q[6];
                            lx_q <= resp_q[7];
                            ly_q <= resp_q[8];
                        end
                        valid_q <= 1'b1;
                    end else begin
                        err_q <= 1'b1;
                    end
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    cs_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign PS2_CS      = cs_q;
    assign keys        = keys_q;
    assign stick_rx    = rx_q;
    assign stick_ry    = ry_q;
    assign stick_lx    = lx_q;
    assign stick_ly    = ly_q;
    assign pad_id      = pad_id_q;
    assign frame_valid = valid_q;
    assign frame_err   = err_q;

endmodule

// File: tb/tb_pstwo_poll_engine.sv
// ----------------------------------------------------------------------------
// tb_pstwo_poll_engine
// Directed stimulus with a pad model on the pins; expected frame results are
// queued by the stimulus and compared by a monitor on frame_valid/frame_err.
// ----------------------------------------------------------------------------
module tb_pstwo_poll_engine;

    localparam int CLK_HALF    = 4;
    localparam int BYTE_GAP    = 10;
    localparam int CS_SETUP    = 6;
    localparam int POLL_PERIOD = 2000;
    localparam int CNT_W       = 12;
    localparam int FRAME_LEN   = 2*CS_SETUP + 72*2*CLK_HALF + 8*BYTE_GAP + 2;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        enable = 1'b0;
    logic        poll_req = 1'b0;
    logic        PS2_DI = 1'b1;
    logic        busy, PS2_CS, PS2_CLK, PS2_DO;
    logic [15:0] keys;
    logic [7:0]  stick_rx, stick_ry, stick_lx, stick_ly, pad_id;
    logic        frame_valid, frame_err;

    pstwo_poll_engine #(
        .CLK_HALF    (CLK_HALF),
        .BYTE_GAP    (BYTE_GAP),
        .CS_SETUP    (CS_SETUP),
        .POLL_PERIOD (POLL_PERIOD),
        .CNT_W       (CNT_W)
    ) dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .enable      (enable),
        .poll_req    (poll_req),
        .busy        (busy),
        .PS2_CS      (PS2_CS),
        .PS2_CLK     (PS2_CLK),
        .PS2_DO      (PS2_DO),
        .PS2_DI      (PS2_DI),
        .keys        (keys),
        .stick_rx    (stick_rx),
        .stick_ry    (stick_ry),
        .stick_lx    (stick_lx),
        .stick_ly    (stick_ly),
        .pad_id      (pad_id),
        .frame_valid (frame_valid),
        .frame_err   (frame_err)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        bit          err;
        logic [15:0] keys;
        logic [7:0]  rx, ry, lx, ly, id;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;

    logic [7:0] pad_resp [9];
    logic [7:0] cmd_cap  [9];
    logic [7:0] exp_cmd  [9] = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    int         pad_byte = 0;
    int         pad_bit = 0;
    logic       pad_cs_prev = 1'b1;
    logic       pad_clk_prev = 1'b1;

    int         run_len = 0;
    int         last_len = 0;
    logic       busy_prev = 1'b0;
    logic       cs_prev = 1'b1;
    int         last_cs_fall = 0;
    int         cs_gap = 0;
    int         n_cs_fall = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Cycle counter for spacing measurements.
    always @(posedge PCLK) cyc++;

    // Pad model: shifts response bits out on CLK falling, captures DO on CLK rising.
    always @(PS2_CS or PS2_CLK) begin
        if (pad_cs_prev === 1'b1 && PS2_CS === 1'b0) begin
            pad_byte = 0;
            pad_bit  = 0;
        end
        if (PS2_CS === 1'b0 && pad_byte < 9) begin
            if (pad_clk_prev === 1'b1 && PS2_CLK === 1'b0) begin
                PS2_DI = pad_resp[pad_byte][pad_bit];
            end else if (pad_clk_prev === 1'b0 && PS2_CLK === 1'b1) begin
                cmd_cap[pad_byte][pad_bit] = PS2_DO;
                if (pad_bit == 7) begin
                    pad_bit = 0;
                    pad_byte++;
                end else begin
                    pad_bit++;
                end
            end
        end
        pad_cs_prev  = PS2_CS;
        pad_clk_prev = PS2_CLK;
    end

    // Monitor: busy length, CS spacing, and scoreboard comparison per frame.
    always @(negedge PCLK) begin
        if (busy === 1'b1) begin
            run_len++;
        end else if (busy_prev === 1'b1) begin
            last_len = run_len;
            run_len  = 0;
        end
        busy_prev = busy;
        if (cs_prev === 1'b1 && PS2_CS === 1'b0) begin
            cs_gap       = cyc - last_cs_fall;
            last_cs_fall = cyc;
            n_cs_fall++;
        end
        cs_prev = PS2_CS;
        if (frame_valid === 1'b1 || frame_err === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_frame: actual valid=%0b err=%0b required no pulse",
                         frame_valid, frame_err);
            end else begin
                mon_e = sb_q.pop_front();
                chk("frame_valid", {31'd0, frame_valid}, {31'd0, !mon_e.err});
                chk("frame_err",   {31'd0, frame_err},   {31'd0, mon_e.err});
                chk("keys",     {16'd0, keys},     {16'd0, mon_e.keys});
                chk("stick_rx", {24'd0, stick_rx}, {24'd0, mon_e.rx});
                chk("stick_ry", {24'd0, stick_ry}, {24'd0, mon_e.ry});
                chk("stick_lx", {24'd0, stick_lx}, {24'd0, mon_e.lx});
                chk("stick_ly", {24'd0, stick_ly}, {24'd0, mon_e.ly});
                chk("pad_id",   {24'd0, pad_id},   {24'd0, mon_e.id});
                chk("frame_len", last_len, FRAME_LEN);
                for (int k = 0; k < 9; k++) begin
                    chk($sformatf("cmd_byte%0d", k), {24'd0, cmd_cap[k]}, {24'd0, exp_cmd[k]});
                end
            end
        end
    end

    task automatic set_resp(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7, b8);
        pad_resp[0] = b0; pad_resp[1] = b1; pad_resp[2] = b2;
        pad_resp[3] = b3; pad_resp[4] = b4; pad_resp[5] = b5;
        pad_resp[6] = b6; pad_resp[7] = b7; pad_resp[8] = b8;
    endtask

    task automatic push_exp(input bit err, input logic [15:0] k,
                            input logic [7:0] rx, ry, lx, ly, id);
        exp_t e;
        e.err = err; e.keys = k; e.rx = rx; e.ry = ry; e.lx = lx; e.ly = ly; e.id = id;
        sb_q.push_back(e);
    endtask

    task automatic issue_poll();
        @(negedge PCLK);
        poll_req = 1'b1;
        @(negedge PCLK);
        poll_req = 1'b0;
    endtask

    task automatic wait_sb(input string name, input int max_cyc);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < max_cyc) begin
            @(negedge PCLK);
            n++;
        end
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: timeout with %0d frames outstanding, required 0", name, sb_q.size());
            sb_q.delete();
        end
        repeat (3) @(negedge PCLK);
    endtask

    task automatic wait_cs(input string name, input int target, input int max_cyc);
        int n;
        n = 0;
        while (n_cs_fall < target && n < max_cyc) begin
            @(negedge PCLK);
            n++;
        end
        chk(name, n_cs_fall, target);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cs"},   {31'd0, PS2_CS},  32'd1);
        chk({tag, "_clk"},  {31'd0, PS2_CLK}, 32'd1);
        chk({tag, "_do"},   {31'd0, PS2_DO},  32'd1);
        chk({tag, "_busy"}, {31'd0, busy},    32'd0);
        chk({tag, "_keys"}, {16'd0, keys},    32'h0000FFFF);
        chk({tag, "_rx"},   {24'd0, stick_rx}, 32'h80);
        chk({tag, "_ry"},   {24'd0, stick_ry}, 32'h80);
        chk({tag, "_lx"},   {24'd0, stick_lx}, 32'h80);
        chk({tag, "_ly"},   {24'd0, stick_ly}, 32'h80);
        chk({tag, "_id"},   {24'd0, pad_id},   32'h00);
        chk({tag, "_valid"}, {31'd0, frame_valid}, 32'd0);
        chk({tag, "_err"},   {31'd0, frame_err},   32'd0);
    endtask

    // Global time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout required test completion");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus.
    initial begin
        int base;
        int n;
        set_resp(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        repeat (5) @(negedge PCLK);
        chk_reset_outputs("in_reset");
        PRESETn = 1'b1;
        repeat (100) @(negedge PCLK);
        chk_reset_outputs("idle");

        // Analog pad, valid frame.
        set_resp(8'hFF, 8'h73, 8'h5A, 8'hEF, 8'hFE, 8'h10, 8'h20, 8'h30, 8'h40);
        push_exp(1'b0, 16'hFEEF, 8'h10, 8'h20, 8'h30, 8'h40, 8'h73);
        issue_poll();
        wait_sb("analog_frame", 2000);

        // Bad signature: outputs hold the previous frame.
        set_resp(8'hFF, 8'h73, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44);
        push_exp(1'b1, 16'hFEEF, 8'h10, 8'h20, 8'h30, 8'h40, 8'h73);
        issue_poll();
        wait_sb("bad_sig_frame", 2000);

        // Digital pad: sticks forced to centre.
        set_resp(8'hFF, 8'h41, 8'h5A, 8'h7F, 8'hBF, 8'h55, 8'h55, 8'h55, 8'h55);
        push_exp(1'b0, 16'hBF7F, 8'h80, 8'h80, 8'h80, 8'h80, 8'h41);
        issue_poll();
        wait_sb("digital_frame", 2000);

        // Auto-poll: two frames, poll_req while busy ignored, enable dropped mid-frame.
        set_resp(8'hFF, 8'h73, 8'h5A, 8'hFD, 8'hFB, 8'h01, 8'h02, 8'h03, 8'h04);
        push_exp(1'b0, 16'hFBFD, 8'h01, 8'h02, 8'h03, 8'h04, 8'h73);
        push_exp(1'b0, 16'hFBFD, 8'h01, 8'h02, 8'h03, 8'h04, 8'h73);
        base = n_cs_fall;
        @(negedge PCLK);
        enable = 1'b1;
        wait_cs("auto_first_start", base + 1, POLL_PERIOD + 200);
        repeat (50) @(negedge PCLK);
        chk("busy_during_frame", {31'd0, busy}, 32'd1);
        issue_poll();
        wait_cs("auto_second_start", base + 2, POLL_PERIOD + FRAME_LEN + 200);
        chk("auto_spacing", cs_gap, POLL_PERIOD + FRAME_LEN);
        @(negedge PCLK);
        enable = 1'b0;
        wait_sb("auto_frames", 2 * FRAME_LEN);
        repeat (POLL_PERIOD + 500) @(negedge PCLK);
        chk("no_poll_after_disable", n_cs_fall, base + 2);

        // Reset during byte 4, then a clean frame.
        set_resp(8'hFF, 8'h73, 8'h5A, 8'h12, 8'h34, 8'hA1, 8'hA2, 8'hA3, 8'hA4);
        issue_poll();
        n = 0;
        while (!(pad_byte == 4 && pad_bit >= 3) && n < 2 * FRAME_LEN) begin
            @(negedge PCLK);
            n++;
        end
        chk("reached_byte4", pad_byte, 4);
        PRESETn = 1'b0;
        @(negedge PCLK);
        chk_reset_outputs("mid_reset");
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
        repeat (5) @(negedge PCLK);
        push_exp(1'b0, 16'h3412, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h73);
        issue_poll();
        wait_sb("post_reset_frame", 2000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
